csr_access_ctrl: RTL and testbench
==================================

Name: csr_access_ctrl

Overview:
- Sequences one Zicsr instruction (CSRRW/CSRRS/CSRRC and the immediate forms) against the CSR file.
- Sits between the execute stage and the CSR file.
- Accepts a request on a valid/ready handshake and drives the CSR file's read strobe, then its write strobe.
- Computes the read-modify-write value, applies the x0/zimm=0 suppression rules and returns rd data plus an exception flag on a valid/ready response.

Parameters:
XLEN, 32, data width of CSR values and rs1 operand

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
req_valid  input  1  execute stage presents a CSR instruction
req_ready  output  1  controller idle, can accept
req_funct3  input  3  instruction funct3
req_csr_num  input  12  CSR address
req_rs1_value  input  XLEN  rs1 register value
req_rs1_idx  input  5  rs1 index, or zimm for immediate forms
req_rd_idx  input  5  rd index
flush  input  1  abort in-flight access (trap/branch squash)
resp_valid  output  1  result available
resp_ready  input  1  writeback accepts result
resp_rd_value  output  XLEN  old CSR value for rd (0 if not read)
resp_exception  output  1  illegal instruction
csr_num  output  12  to CSR file
read_csr  output  1  CSR file read strobe
read_value  input  XLEN  CSR file read data (combinational)
write_csr  output  1  CSR file write strobe
write_function  output  3  funct3 forwarded to CSR file
write_value  output  XLEN  final value to write
illegal_instr_exception  input  1  CSR file illegal flag (combinational)

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. Outputs are decoded from the registered state (Moore).
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rd_value=0, resp_exception=0, read_csr=0, write_csr=0, csr_num=0, write_function=0, write_value=0.
- Accept: in IDLE with req_valid=1, latch funct3, csr_num, src and rd_idx. req_ready=1 only in IDLE.
- src: when funct3[2]=1 it is the zero-extended req_rs1_idx; otherwise it is req_rs1_value.
- do_read: 0 for RW/RWI when rd_idx=0; 1 otherwise.
- do_write: 0 for RS/RC/RSI/RCI when rs1_idx=0; 1 otherwise.
- funct3 of 000 or 100: go to RESP with exception=1; no CSR strobes.
- IDLE transitions on accept: do_read=1 -> READ; else do_write=1 -> WRITE. Both false cannot occur.
- READ (1 cycle): read_csr=1 and csr_num driven. Capture read_value into old and into resp_rd_value, and capture illegal_instr_exception.
  - Illegal -> RESP with exception=1.
  - Otherwise do_write -> WRITE, else -> RESP.
- WRITE (1 cycle): write_csr=1, write_function=funct3.
  - write_value: src for RW; old|src for RS; old&~src for RC.
  - If illegal_instr_exception is sampled high, resp_exception=1 and resp_rd_value is forced to 0.
  - Next state: RESP.
- RESP: resp_valid=1 and outputs held stable until resp_ready=1, then IDLE. A new request is accepted no earlier than the following cycle.
- Latency (accept cycle = 0): RS with write -> resp_valid in cycle 3. RW with rd=x0 -> cycle 2. RS with rs1=x0 -> cycle 2.
- Strobes are single-cycle; read_csr and write_csr are never high in the same cycle. When the strobes are low, csr_num/write_value hold their last values.
- flush has priority over all transitions and returns to IDLE next cycle.
  - In READ or WRITE, the strobe in the flush cycle is suppressed, so a flushed write never reaches the CSR file.
  - In RESP, resp_valid drops.
  - In IDLE, the request is not accepted.
- Reset mid-operation: immediate return to reset values; no strobe in the reset cycle.

Optional Feature:
- Macro: CSR_RO_PRECHECK_EN.
- When defined: on accept, if do_write=1 and csr_num[11:10]=2'b11 (read-only space), go directly to RESP with exception=1. No read or write strobe is issued; latency is 1.
- When undefined: read-only violations are detected only through illegal_instr_exception from the CSR file during WRITE.

Test Plan:
- CSRRS x5, 0xC00 (cycle), rs1=x0; CSR file returns 0x0000_1234 -> one read_csr pulse, no write_csr, resp_rd_value=0x1234, exception=0, resp_valid in cycle 2.
- CSRRC 0x340, rs1_value=0x0F, old=0xFF -> read then write, write_value=0xF0, resp_rd_value=0xFF, resp_valid in cycle 3.
- CSRRWI 0x340, zimm=5, rd=x0 -> no read_csr, write_value=0x5, resp_rd_value=0, resp_valid in cycle 2.
- CSRRW 0xC01 (time, read-only), rs1=x3, file flags illegal on write -> resp_exception=1, resp_rd_value=0. With CSR_RO_PRECHECK_EN: no strobes, resp_valid in cycle 1.
- funct3=100 -> resp_exception=1, no strobes. Hold resp_ready=0 for 3 cycles -> resp_valid and resp data stay stable, req_ready=0 throughout.
- CSRRS with write, flush asserted in WRITE cycle -> write_csr stays 0, IDLE next cycle, req_ready=1. Reset asserted in READ -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/csr_access_ctrl_if.sv
// rtl/csr_access_ctrl_if.sv - request/response handshake and CSR file port bundle for csr_access_ctrl
interface csr_access_ctrl_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_csr_num;
    logic [XLEN-1:0] req_rs1_value;
    logic [4:0]      req_rs1_idx;
    logic [4:0]      req_rd_idx;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rd_value;
    logic            resp_exception;
    logic [11:0]     csr_num;
    logic            read_csr;
    logic [XLEN-1:0] read_value;
    logic            write_csr;
    logic [2:0]      write_function;
    logic [XLEN-1:0] write_value;
    logic            illegal_instr_exception;

    modport slave (
        input  req_valid, req_funct3, req_csr_num, req_rs1_value, req_rs1_idx, req_rd_idx,
        input  flush, resp_ready, read_value, illegal_instr_exception,
        output req_ready, resp_valid, resp_rd_value, resp_exception,
        output csr_num, read_csr, write_csr, write_function, write_value
    );

    modport master (
        output req_valid, req_funct3, req_csr_num, req_rs1_value, req_rs1_idx, req_rd_idx,
        output flush, resp_ready, read_value, illegal_instr_exception,
        input  req_ready, resp_valid, resp_rd_value, resp_exception,
        input  csr_num, read_csr, write_csr, write_function, write_value
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// rtl/csr_access_ctrl.sv - Zicsr read-modify-write sequencer between execute and the CSR file
// Optional macro CSR_RO_PRECHECK_EN rejects writes to the read-only CSR space at accept time.
module csr_access_ctrl #(
    parameter int XLEN = 32
) (
    input logic              clock,
    input logic              reset,
    csr_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] src_q;
    logic            do_write_q;
    logic [11:0]     csr_num_q;
    logic [XLEN-1:0] write_value_q;
    logic [2:0]      write_function_q;
    logic [XLEN-1:0] resp_rd_value_q;
    logic            resp_exception_q;

    logic            acc_bad;
    logic            acc_do_read;
    logic            acc_do_write;
    logic            acc_exc;
    logic [XLEN-1:0] acc_src;
    logic [XLEN-1:0] wv_next;

    function automatic logic [XLEN-1:0] rmw(input logic [XLEN-1:0] old,
                                            input logic [XLEN-1:0] src,
                                            input logic [2:0] f3);
        case (f3[1:0])
            2'b10:   rmw = old | src;
            2'b11:   rmw = old & ~src;
            default: rmw = src;
        endcase
    endfunction

    // Request decode: funct3[1:0]==00 is not a Zicsr op; x0/zimm=0 suppress the unneeded access.
    always_comb begin
        acc_bad      = (bus.req_funct3[1:0] == 2'b00);
        acc_do_read  = !((bus.req_funct3[1:0] == 2'b01) && (bus.req_rd_idx == 5'd0));
        acc_do_write = !((bus.req_funct3[1:0] != 2'b01) && (bus.req_rs1_idx == 5'd0));
        acc_src      = bus.req_funct3[2] ? {{(XLEN-5){1'b0}}, bus.req_rs1_idx} : bus.req_rs1_value;
`ifdef CSR_RO_PRECHECK_EN
        acc_exc      = acc_bad || (acc_do_write && (bus.req_csr_num[11:10] == 2'b11));
`else
        acc_exc      = acc_bad;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.resp_valid = 1'b0;
        bus.read_csr  = 1'b0;
        bus.write_csr = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (acc_exc)          state_d = RESP;
                    else if (acc_do_read) state_d = READ;
                    else                  state_d = WRITE;
                end
            end
            READ: begin
                bus.read_csr = !bus.flush && !reset;
                if (bus.illegal_instr_exception) state_d = RESP;
                else if (do_write_q)             state_d = WRITE;
                else                             state_d = RESP;
            end
            WRITE: begin
                bus.write_csr = !bus.flush && !reset;
                state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    // Write data is prepared on entry to WRITE so it is stable for the whole strobe cycle.
    assign wv_next = (state_q == READ) ? rmw(bus.read_value, src_q, funct3_q)
                                       : rmw({XLEN{1'b0}}, acc_src, bus.req_funct3);

    always_ff @(posedge clock) begin
        if (reset) begin
            funct3_q         <= 3'd0;
            src_q            <= '0;
            do_write_q       <= 1'b0;
            csr_num_q        <= 12'd0;
            write_value_q    <= '0;
            write_function_q <= 3'd0;
            resp_rd_value_q  <= '0;
            resp_exception_q <= 1'b0;
        end else if (!bus.flush) begin
            if (state_q == IDLE && bus.req_valid) begin
                funct3_q         <= bus.req_funct3;
                src_q            <= acc_src;
                do_write_q       <= acc_do_write;
                csr_num_q        <= bus.req_csr_num;
                resp_rd_value_q  <= '0;
                resp_exception_q <= acc_exc;
            end
            if (state_q == READ) begin
                resp_rd_value_q <= bus.read_value;
                if (bus.illegal_instr_exception) resp_exception_q <= 1'b1;
            end
            if (state_q == WRITE && bus.illegal_instr_exception) begin
                resp_exception_q <= 1'b1;
                resp_rd_value_q  <= '0;
            end
            if (state_d == WRITE) begin
                write_value_q    <= wv_next;
                write_function_q <= (state_q == READ) ? funct3_q : bus.req_funct3;
            end
        end
    end

    assign bus.csr_num        = csr_num_q;
    assign bus.write_value    = write_value_q;
    assign bus.write_function = write_function_q;
    assign bus.resp_rd_value  = resp_rd_value_q;
    assign bus.resp_exception = resp_exception_q;
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb/tb_csr_access_ctrl.sv - directed scoreboard bench for csr_access_ctrl
module tb_csr_access_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    csr_access_ctrl_if #(.XLEN(32)) bus();
    csr_access_ctrl #(.XLEN(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    logic [31:0] file_value = 32'h0;
    logic        ill_on_read = 1'b0;
    logic        ill_on_write = 1'b0;
    assign bus.read_value = file_value;
    assign bus.illegal_instr_exception = (ill_on_read & bus.read_csr) | (ill_on_write & bus.write_csr);

    typedef struct packed {
        logic [31:0] rd;
        logic        exc;
    } resp_t;
    resp_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [2:0] f3, input logic [11:0] csr, input logic [31:0] rs1v,
                           input logic [4:0] rs1i, input logic [4:0] rd,
                           input logic [31:0] exp_rd, input logic exp_exc, input int exp_lat,
                           input int exp_reads, input int exp_writes, input logic [31:0] exp_wv,
                           input logic [2:0] exp_wf, input int hold);
        int reads, writes, cyc;
        logic [31:0] wv, hold_rd;
        logic [2:0]  wf;
        resp_t exp;
        @(negedge clock);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_funct3    = f3;
        bus.req_csr_num   = csr;
        bus.req_rs1_value = rs1v;
        bus.req_rs1_idx   = rs1i;
        bus.req_rd_idx    = rd;
        bus.req_valid     = 1'b1;
        sb.push_back('{rd: exp_rd, exc: exp_exc});
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        reads = 0; writes = 0; cyc = 0; wv = 32'h0; wf = 3'd0;
        do begin
            @(negedge clock);
            cyc++;
            chk("no_dual_strobe", 32'(bus.read_csr & bus.write_csr), 32'd0);
            if (bus.read_csr) reads++;
            if (bus.write_csr) begin
                writes++;
                wv = bus.write_value;
                wf = bus.write_function;
            end
        end while (!bus.resp_valid && cyc < 20);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("read_pulses", 32'(reads), 32'(exp_reads));
        chk("write_pulses", 32'(writes), 32'(exp_writes));
        if (exp_writes > 0) begin
            chk("write_value", wv, exp_wv);
            chk("write_function", 32'(wf), 32'(exp_wf));
        end
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            chk("resp_rd_value", bus.resp_rd_value, exp.rd);
            chk("resp_exception", 32'(bus.resp_exception), 32'(exp.exc));
        end
        hold_rd = bus.resp_rd_value;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_rd_stable", bus.resp_rd_value, hold_rd);
            chk("hold_exc_stable", 32'(bus.resp_exception), 32'(exp_exc));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1 bus.resp_ready = 1'b0;
        @(negedge clock);
        chk("back_to_idle", 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_funct3 = 3'd0; bus.req_csr_num = 12'd0;
        bus.req_rs1_value = 32'd0; bus.req_rs1_idx = 5'd0; bus.req_rd_idx = 5'd0;
        bus.flush = 1'b0; bus.resp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_strobes", 32'({bus.read_csr, bus.write_csr}), 32'd0);
        chk("rst_csr_num", 32'(bus.csr_num), 32'd0);
        chk("rst_write_value", bus.write_value, 32'd0);

        // CSRRS x5, cycle, x0: read only
        file_value = 32'h0000_1234;
        run_req(3'b010, 12'hC00, 32'hFFFF_FFFF, 5'd0, 5'd5, 32'h1234, 1'b0, 2, 1, 0, 32'h0, 3'd0, 0);
        // CSRRC 0x340
        file_value = 32'h0000_00FF;
        run_req(3'b011, 12'h340, 32'h0000_000F, 5'd1, 5'd2, 32'hFF, 1'b0, 3, 1, 1, 32'hF0, 3'b011, 0);
        // CSRRWI zimm=5, rd=x0: write only
        run_req(3'b101, 12'h340, 32'hDEAD_BEEF, 5'd5, 5'd0, 32'h0, 1'b0, 2, 0, 1, 32'h5, 3'b101, 0);
        // CSRRS set bits
        file_value = 32'h0000_00FF;
        run_req(3'b010, 12'h300, 32'h0000_0F00, 5'd4, 5'd9, 32'hFF, 1'b0, 3, 1, 1, 32'h0FFF, 3'b010, 0);
        // CSRRW plain
        file_value = 32'h0000_0055;
        run_req(3'b001, 12'h305, 32'h1000_0000, 5'd6, 5'd1, 32'h55, 1'b0, 3, 1, 1, 32'h1000_0000, 3'b001, 0);
        // CSRRW to read-only time CSR
        file_value = 32'h0000_ABCD;
        ill_on_write = 1'b1;
`ifdef CSR_RO_PRECHECK_EN
        run_req(3'b001, 12'hC01, 32'h77, 5'd3, 5'd7, 32'h0, 1'b1, 1, 0, 0, 32'h0, 3'd0, 0);
`else
        run_req(3'b001, 12'hC01, 32'h77, 5'd3, 5'd7, 32'h0, 1'b1, 3, 1, 1, 32'h77, 3'b001, 0);
`endif
        ill_on_write = 1'b0;
        // funct3=100 with backpressure
        run_req(3'b100, 12'h340, 32'h1, 5'd1, 5'd1, 32'h0, 1'b1, 1, 0, 0, 32'h0, 3'd0, 3);

        // Flush in WRITE suppresses the write strobe
        file_value = 32'h1;
        @(negedge clock);
        bus.req_funct3 = 3'b010; bus.req_csr_num = 12'h300; bus.req_rs1_value = 32'h8;
        bus.req_rs1_idx = 5'd2; bus.req_rd_idx = 5'd3; bus.req_valid = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        chk("flush_read_strobe", 32'(bus.read_csr), 32'd1);
        @(negedge clock);
        bus.flush = 1'b1;
        #1 chk("flush_write_suppressed", 32'(bus.write_csr), 32'd0);
        @(posedge clock);
        #1 bus.flush = 1'b0;
        @(negedge clock);
        chk("flush_idle_ready", 32'(bus.req_ready), 32'd1);
        chk("flush_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("flush_no_write", 32'(bus.write_csr), 32'd0);

        // Flush in IDLE blocks acceptance
        bus.req_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clock);
        #1 begin bus.req_valid = 1'b0; bus.flush = 1'b0; end
        @(negedge clock);
        chk("idle_flush_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_flush_no_read", 32'(bus.read_csr), 32'd0);

        // Reset in READ
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1 chk("reset_cycle_no_strobe", 32'(bus.read_csr), 32'd0);
        @(posedge clock);
        @(negedge clock);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_rd_value", bus.resp_rd_value, 32'd0);
        chk("mid_rst_exc", 32'(bus.resp_exception), 32'd0);
        chk("mid_rst_csr_num", 32'(bus.csr_num), 32'd0);
        chk("mid_rst_wv", bus.write_value, 32'd0);
        chk("mid_rst_wf", 32'(bus.write_function), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
